// File: rtl/npc_exec_core_if.sv
// Bus bundle between the npc datapath (master) and the execute core (slave):
// register file ports, ALU operands/result and the funct3 decode.
interface npc_exec_core_if #(
  parameter int DATA_W = 32
);
  logic              wen;
  logic [4:0]        waddr;
  logic [DATA_W-1:0] wdata;
  logic [4:0]        raddr1;
  logic [4:0]        raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic [9:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic [2:0]        funct3;
  logic [7:0]        funct3_d;

  modport master (
    output wen, waddr, wdata, raddr1, raddr2, alu_src1, alu_src2, alu_op, funct3,
    input  rdata1, rdata2, alu_result, funct3_d
  );

  modport slave (
    input  wen, waddr, wdata, raddr1, raddr2, alu_src1, alu_src2, alu_op, funct3,
    output rdata1, rdata2, alu_result, funct3_d
  );
endinterface

// File: rtl/npc_exec_core.sv
// Execute core for the single-cycle npc RV32 CPU: register file, one-hot ALU and funct3 decoder.
// Define NPC_EXEC_RV32E_EN to shrink the register file to x0..x15 (RV32E).
module npc_exec_core #(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  npc_exec_core_if.slave  bus
);

`ifdef NPC_EXEC_RV32E_EN
  localparam int NREGS = 16;
  localparam int AW    = 4;

  // x0 and anything with index bit 4 set do not exist as storage.
  function automatic logic regValid(input logic [4:0] a);
    return (a != 5'd0) && !a[4];
  endfunction
`else
  localparam int NREGS = 32;
  localparam int AW    = 5;

  function automatic logic regValid(input logic [4:0] a);
    return a != 5'd0;
  endfunction
`endif

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic [DATA_W-1:0] w_alu;
  logic [4:0]        w_shamt;
  logic              w_slt;
  logic              w_sltu;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.wen && regValid(bus.waddr)) begin
      r_regs[bus.waddr[AW-1:0]] <= bus.wdata;
    end
  end

  // No write-to-read bypass: a same-cycle read sees the pre-edge contents.
  always_comb begin
    w_rdata1 = regValid(bus.raddr1) ? r_regs[bus.raddr1[AW-1:0]] : '0;
    w_rdata2 = regValid(bus.raddr2) ? r_regs[bus.raddr2[AW-1:0]] : '0;
  end

  always_comb begin
    w_shamt = bus.alu_src2[4:0];
    w_slt   = $signed(bus.alu_src1) < $signed(bus.alu_src2);
    w_sltu  = bus.alu_src1 < bus.alu_src2;
    w_alu   = '0;
    // AND-OR mux: multiple select bits OR their results together.
    w_alu = w_alu | ({DATA_W{bus.alu_op[0]}} & (bus.alu_src1 + bus.alu_src2));
    w_alu = w_alu | ({DATA_W{bus.alu_op[1]}} & (bus.alu_src1 - bus.alu_src2));
    w_alu = w_alu | ({DATA_W{bus.alu_op[2]}} & (bus.alu_src1 & bus.alu_src2));
    w_alu = w_alu | ({DATA_W{bus.alu_op[3]}} & (bus.alu_src1 | bus.alu_src2));
    w_alu = w_alu | ({DATA_W{bus.alu_op[4]}} & (bus.alu_src1 ^ bus.alu_src2));
    w_alu = w_alu | ({DATA_W{bus.alu_op[5]}} & (bus.alu_src1 << w_shamt));
    w_alu = w_alu | ({DATA_W{bus.alu_op[6]}} & (bus.alu_src1 >> w_shamt));
    w_alu = w_alu | ({DATA_W{bus.alu_op[7]}} & DATA_W'($signed(bus.alu_src1) >>> w_shamt));
    w_alu = w_alu | ({DATA_W{bus.alu_op[8]}} & {{(DATA_W-1){1'b0}}, w_slt});
    w_alu = w_alu | ({DATA_W{bus.alu_op[9]}} & {{(DATA_W-1){1'b0}}, w_sltu});
  end

  assign bus.rdata1     = w_rdata1;
  assign bus.rdata2     = w_rdata2;
  assign bus.alu_result = w_alu;
  assign bus.funct3_d   = 8'b0000_0001 << bus.funct3;

endmodule

// File: tb/tb_npc_exec_core.sv
// Self-checking bench for npc_exec_core: a reference model checked every cycle
// plus directed vectors with hand-computed expectations.
module tb_npc_exec_core;

`ifdef NPC_EXEC_RV32E_EN
  localparam int LIMIT = 16;
`else
  localparam int LIMIT = 32;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic cmpEn;

  logic [31:0] mdl [32];

  npc_exec_core_if #(.DATA_W(32)) bus ();

  npc_exec_core #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural register state as the datapath would see it.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] <= 32'd0;
    end else if (bus.wen && bus.waddr != 5'd0 && int'(bus.waddr) < LIMIT) begin
      mdl[bus.waddr] <= bus.wdata;
    end
  end

  function automatic logic [31:0] mdlRead(input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= LIMIT) return 32'd0;
    return mdl[a];
  endfunction

  function automatic logic [31:0] mdlAlu(input logic [31:0] a, input logic [31:0] b, input logic [9:0] op);
    logic [31:0] r;
    logic [31:0] fill;
    int          sa;
    int          sb;
    int          sh;
    r  = 32'd0;
    sa = a;
    sb = b;
    sh = int'(b % 32);
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
    if (op[0]) r = r | (a + b);
    if (op[1]) r = r | (a + ~b + 32'd1);
    if (op[2]) r = r | (a & b);
    if (op[3]) r = r | (a | b);
    if (op[4]) r = r | (a ^ b);
    if (op[5]) r = r | (a << sh);
    if (op[6]) r = r | (a >> sh);
    if (op[7]) r = r | ((a >> sh) | fill);
    if (op[8]) r = r | ((sa < sb) ? 32'd1 : 32'd0);
    if (op[9]) r = r | (({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Model comparison on every falling edge once reset has initialised the file.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("mdl_rdata1", bus.rdata1, mdlRead(bus.raddr1));
      checkOutput("mdl_rdata2", bus.rdata2, mdlRead(bus.raddr2));
      checkOutput("mdl_alu", bus.alu_result, mdlAlu(bus.alu_src1, bus.alu_src2, bus.alu_op));
      checkOutput("mdl_funct3_d", {24'd0, bus.funct3_d}, 32'(2 ** int'(bus.funct3)));
    end
  end

  // Drive one cycle of inputs just after the rising edge; return after the falling edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra1, input logic [4:0] ra2,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [9:0] op, input logic [2:0] f3);
    @(posedge clk);
    #1;
    reset        = r;
    bus.wen      = w;
    bus.waddr    = wa;
    bus.wdata    = wd;
    bus.raddr1   = ra1;
    bus.raddr2   = ra2;
    bus.alu_src1 = a;
    bus.alu_src2 = b;
    bus.alu_op   = op;
    bus.funct3   = f3;
    @(negedge clk);
    #1;
  endtask

  task automatic readRegs(input logic [4:0] ra1, input logic [4:0] ra2);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, ra1, ra2, 32'd0, 32'd0, 10'd0, 3'd0);
  endtask

  task automatic writeReg(input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra1);
    applyStimulus(1'b0, 1'b1, wa, wd, ra1, 5'd0, 32'd0, 32'd0, 10'd0, 3'd0);
  endtask

  task automatic aluCase(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [9:0] op, input logic [31:0] expected);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, a, b, op, 3'd0);
    checkOutput(name, bus.alu_result, expected);
  endtask

  logic [7:0] decTable [8];

  initial begin
    checks   = 0;
    failures = 0;
    cmpEn    = 1'b0;
    decTable[0] = 8'h01; decTable[1] = 8'h02; decTable[2] = 8'h04; decTable[3] = 8'h08;
    decTable[4] = 8'h10; decTable[5] = 8'h20; decTable[6] = 8'h40; decTable[7] = 8'h80;

    reset        = 1'b1;
    bus.wen      = 1'b0;
    bus.waddr    = 5'd0;
    bus.wdata    = 32'd0;
    bus.raddr1   = 5'd0;
    bus.raddr2   = 5'd0;
    bus.alu_src1 = 32'd0;
    bus.alu_src2 = 32'd0;
    bus.alu_op   = 10'd0;
    bus.funct3   = 3'd0;
    repeat (2) @(posedge clk);
    cmpEn = 1'b1;

    for (int i = 0; i < 32; i++) begin
      readRegs(5'(i), 5'(31 - i));
      checkOutput("reset_rdata1", bus.rdata1, 32'd0);
      checkOutput("reset_rdata2", bus.rdata2, 32'd0);
    end

    writeReg(5'd5, 32'hDEAD_BEEF, 5'd5);
    checkOutput("same_cycle_old_x5", bus.rdata1, 32'd0);
    readRegs(5'd5, 5'd5);
    checkOutput("x5_port1", bus.rdata1, 32'hDEAD_BEEF);
    checkOutput("x5_port2", bus.rdata2, 32'hDEAD_BEEF);

    writeReg(5'd0, 32'h1234_5678, 5'd0);
    readRegs(5'd0, 5'd0);
    checkOutput("x0_hardwired", bus.rdata1, 32'd0);

    writeReg(5'd7, 32'h0000_0033, 5'd0);
    readRegs(5'd7, 5'd5);
    checkOutput("x7_before_reset", bus.rdata1, 32'h0000_0033);
    applyStimulus(1'b1, 1'b1, 5'd7, 32'h0000_0001, 5'd7, 5'd5, 32'd0, 32'd0, 10'd0, 3'd0);
    readRegs(5'd7, 5'd5);
    checkOutput("reset_beats_write_x7", bus.rdata1, 32'd0);
    checkOutput("reset_clears_x5", bus.rdata2, 32'd0);

`ifdef NPC_EXEC_RV32E_EN
    writeReg(5'd20, 32'h0000_00AA, 5'd0);
    readRegs(5'd20, 5'd4);
    checkOutput("rv32e_x20_absent", bus.rdata1, 32'd0);
    checkOutput("rv32e_x4_untouched", bus.rdata2, 32'd0);
`else
    writeReg(5'd20, 32'h0000_00AA, 5'd0);
    readRegs(5'd20, 5'd4);
    checkOutput("x20_written", bus.rdata1, 32'h0000_00AA);
    checkOutput("x4_untouched", bus.rdata2, 32'd0);
`endif
    writeReg(5'd15, 32'h0000_00AA, 5'd0);
    readRegs(5'd15, 5'd31);
    checkOutput("x15_written", bus.rdata1, 32'h0000_00AA);

    aluCase("alu_add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 10'h001, 32'h0000_0000);
    aluCase("alu_sub_wrap", 32'h0000_0000, 32'h0000_0001, 10'h002, 32'hFFFF_FFFF);
    aluCase("alu_and", 32'h0000_F0F0, 32'h0000_FF00, 10'h004, 32'h0000_F000);
    aluCase("alu_and_or", 32'h0000_F0F0, 32'h0000_FF00, 10'h00C, 32'h0000_FFF0);
    aluCase("alu_add_xor", 32'h0000_0003, 32'h0000_0005, 10'h011, 32'h0000_000E);
    aluCase("alu_sll_mask", 32'h0000_0001, 32'h0000_0021, 10'h020, 32'h0000_0002);
    aluCase("alu_srl", 32'h8000_0000, 32'h0000_0004, 10'h040, 32'h0800_0000);
    aluCase("alu_sra", 32'h8000_0000, 32'h0000_0024, 10'h080, 32'hF800_0000);
    aluCase("alu_slt", 32'hFFFF_FFFF, 32'h0000_0001, 10'h100, 32'h0000_0001);
    aluCase("alu_sltu", 32'hFFFF_FFFF, 32'h0000_0001, 10'h200, 32'h0000_0000);
    aluCase("alu_none", 32'h1234_5678, 32'h9ABC_DEF0, 10'h000, 32'h0000_0000);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 10'd0, 3'(i));
      checkOutput("funct3_decode", {24'd0, bus.funct3_d}, {24'd0, decTable[i]});
    end

    for (int i = 1; i < 32; i++) begin
      writeReg(5'(i), 32'hA500_0000 | 32'(i * 32'h0101_0101), 5'(i - 1));
    end
    for (int i = 0; i < 32; i++) begin
      readRegs(5'(i), 5'(31 - i));
    end

    for (int n = 0; n < 400; n++) begin
      logic [9:0] op;
      op = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'(1 << $urandom_range(0, 9));
      applyStimulus(($urandom_range(0, 59) == 0), 1'($urandom), 5'($urandom), $urandom,
                    5'($urandom), 5'($urandom), $urandom,
                    ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                    op, 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npc_exec_core.md
# npc_exec_core

Combinational-plus-state execute core for the single-cycle `npc` RV32 processor. It bundles three parts:
- a 32×32 integer register file with two read ports and one write port;
- a one-hot-controlled 32-bit ALU;
- a 3-to-8 one-hot decoder for the instruction `funct3` field.

The top-level datapath drives register addresses, write-back data, ALU operands and `funct3`, and consumes read data, `alu_result` and the decoded `funct3`.

## Interface
Parameters:
- `DATA_W`, default 32: register and ALU data width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock (single clock domain)
- `reset`  in  1  synchronous, active-high reset
- `wen`  in  1  register write enable
- `waddr`  in  5  write register index
- `wdata`  in  32  write-back data
- `raddr1`  in  5  read port 1 index (rs1)
- `raddr2`  in  5  read port 2 index (rs2)
- `rdata1`  out  32  read port 1 data
- `rdata2`  out  32  read port 2 data
- `alu_src1`  in  32  ALU operand A
- `alu_src2`  in  32  ALU operand B
- `alu_op`  in  10  one-hot ALU operation select
- `alu_result`  out  32  ALU result
- `funct3`  in  3  instruction `funct3` field
- `funct3_d`  out  8  one-hot decode of `funct3`

## Operation
Register file:
- 32 entries × 32 bits.
- x0 is hardwired to zero. Writes to index 0 are discarded, and reads of index 0 return 0.
- A write occurs at the rising edge of `clk` when `wen` is 1 and `waddr` is not 0.
- Both read ports are combinational and independent. Reading the same index on both ports is legal.
- There is no write-to-read bypass. A read of `waddr` in the same cycle as its write returns the old value; the new value appears after the edge.

ALU (purely combinational):
- `alu_op` bit assignments:
  - [0] add: A+B
  - [1] sub: A−B
  - [2] and
  - [3] or
  - [4] xor
  - [5] sll: A << B[4:0]
  - [6] srl: logical right shift by B[4:0]
  - [7] sra: arithmetic right shift by B[4:0]
  - [8] slt: signed A<B, result 0 or 1
  - [9] sltu: unsigned A<B, result 0 or 1
- Add and sub wrap modulo 2^32. There is no carry or overflow output.
- Shift amounts use only B[4:0]; B[31:5] is ignored.
- The result is the AND-OR of each op's result gated by its `alu_op` bit:
  - if `alu_op` is all zeros, `alu_result` is 0;
  - if several bits are set, `alu_result` is the bitwise OR of the selected results. This is defined behaviour, not X.

Decoder (purely combinational):
- `funct3_d[i]` = 1 exactly when `funct3` equals i; all other bits are 0.
- Exactly one bit is always set.

## Timing
- Reset:
  - Asserting `reset` at a rising edge clears x1..x31 to 0.
  - `reset` has priority over a simultaneous write; the write is lost.
  - Reset asserted mid-sequence clears all registers at that edge.
- Read latency is 0 cycles: `rdata1`/`rdata2` follow `raddr1`/`raddr2` combinationally.
- Write latency is 1 edge: data written at edge N is readable after edge N.
- ALU and decoder have 0-cycle latency and hold no state. Their outputs do not depend on `reset`.
- Output reset values:
  - `rdata1`/`rdata2`: 0 after reset, for any address.
  - `alu_result` and `funct3_d`: combinational functions of their inputs.
- No handshakes and no stalls. Every cycle is independent.

## Configuration
- `NPC_EXEC_RV32E_EN` defined (RV32E mode):
  - the register file holds 16 entries (x0..x15);
  - writes with `waddr[4]` = 1 are discarded;
  - reads with address bit 4 = 1 return 0.
- `NPC_EXEC_RV32E_EN` undefined: the full 32-entry register file as described above.
- ALU and decoder behaviour are identical in both modes.

## Test plan
- Reset, then read all 32 indices on both ports -> every `rdata` is 0.
- Write x5 = 0xDEADBEEF, then read x5 on port 1 in the next cycle -> 0xDEADBEEF. In the write cycle itself, port 1 reads x5 -> 0 (old value).
- Write x0 = 0x12345678 -> reading x0 returns 0. Assert `reset` and `wen` together on x7 = 0x1 -> x7 reads 0.
- ALU:
  - add 0xFFFFFFFF+1 -> 0x00000000;
  - sub 0−1 -> 0xFFFFFFFF;
  - sra 0x80000000 by 0x24 (shift 4) -> 0xF8000000;
  - slt 0xFFFFFFFF vs 1 -> 1;
  - sltu with the same operands -> 0;
  - `alu_op` = 0 -> 0.
- Sweep `funct3` 0..7 -> `funct3_d` = 0x01, 0x02, 0x04, …, 0x80.
- With `NPC_EXEC_RV32E_EN`: write x20 = 0xAA, then read x20 -> 0. Write x15 = 0xAA, then read x15 -> 0xAA.
